// File: rtl/regfile_wb_ctrl_pkg.sv
// Constants shared by the register-file write front end, the register file and decode.
package regfile_wb_ctrl_pkg;

  localparam int unsigned RF_XLEN   = 32;
  localparam int unsigned RF_REG_AW = 5;
  localparam int unsigned WB_DEPTH  = 4;
  localparam int unsigned REG_ZERO  = 0;

endpackage

// File: rtl/regfile_wb_ctrl_wb_fifo.sv
// In-order write-back queue: storage, pointers and occupancy.
// Per-entry valid bits and rd indices are exported for the scoreboard compare.
module regfile_wb_ctrl_wb_fifo
  import regfile_wb_ctrl_pkg::*;
#(
  parameter int unsigned XLEN   = RF_XLEN,
  parameter int unsigned REG_AW = RF_REG_AW,
  parameter int unsigned DEPTH  = WB_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [REG_AW-1:0]        i_push_rd,
  input  logic [XLEN-1:0]          i_push_data,
  input  logic                     i_pop,
  output logic [REG_AW-1:0]        o_head_rd,
  output logic [XLEN-1:0]          o_head_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [DEPTH-1:0]         o_ent_valid,
  output logic [DEPTH*REG_AW-1:0]  o_ent_rd
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [REG_AW-1:0] r_rd     [DEPTH];
  logic [XLEN-1:0]   r_data   [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [PW:0]       r_count;
  logic [PW-1:0]     w_off;

  // Storage is reset too so the head outputs read zero straight out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_rd[i]   <= '0;
        r_data[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_rd[r_wr_ptr]   <= i_push_rd;
        r_data[r_wr_ptr] <= i_push_data;
        r_wr_ptr         <= r_wr_ptr + 1'b1;
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (i_push && !i_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!i_push && i_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign o_head_rd   = r_rd[r_rd_ptr];
  assign o_head_data = r_data[r_rd_ptr];
  assign o_full      = (r_count == (PW+1)'(DEPTH));
  assign o_empty     = (r_count == '0);
  assign o_count     = r_count;

  // A slot is live when its distance from the head is below the count.
  always_comb begin
    o_ent_valid = '0;
    o_ent_rd    = '0;
    w_off       = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_off                       = PW'(i) - r_rd_ptr;
      o_ent_valid[i]              = ({1'b0, w_off} < r_count);
      o_ent_rd[i*REG_AW +: REG_AW] = r_rd[i];
    end
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file write front end: arbitrates ALU and load writes into an in-order queue,
// drains one write per cycle and answers scoreboard queries on pending destinations.
module regfile_wb_ctrl
  import regfile_wb_ctrl_pkg::*;
#(
  parameter int unsigned XLEN   = RF_XLEN,
  parameter int unsigned REG_AW = RF_REG_AW,
  parameter int unsigned DEPTH  = WB_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [REG_AW-1:0]      alu_rd,
  input  logic [XLEN-1:0]        alu_data,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic [REG_AW-1:0]      ld_rd,
  input  logic [XLEN-1:0]        ld_data,
  input  logic                   wb_hold,
  output logic                   RegWrite,
  output logic [REG_AW-1:0]      wrReg,
  output logic [XLEN-1:0]        wrData,
  input  logic [REG_AW-1:0]      q_rs1,
  input  logic [REG_AW-1:0]      q_rs2,
  output logic                   rs1_busy,
  output logic                   rs2_busy,
  output logic [$clog2(DEPTH):0] occupancy
);

  logic                    w_full;
  logic                    w_empty;
  logic                    w_alu_acc;
  logic                    w_ld_acc;
  logic                    w_push;
  logic                    w_pop;
  logic [REG_AW-1:0]       w_acc_rd;
  logic [XLEN-1:0]         w_acc_data;
  logic [DEPTH-1:0]        w_ent_valid;
  logic [DEPTH*REG_AW-1:0] w_ent_rd;

  // No full pass-through: a pop in the same cycle does not reopen the queue.
  assign alu_ready = !w_full;
  assign ld_ready  = !w_full && !alu_valid;
  assign w_alu_acc = alu_valid && alu_ready;
  assign w_ld_acc  = ld_valid && ld_ready;

  assign w_acc_rd   = w_alu_acc ? alu_rd : ld_rd;
  assign w_acc_data = w_alu_acc ? alu_data : ld_data;

  // Writes to x0 complete the handshake but never occupy a slot.
  assign w_push = (w_alu_acc || w_ld_acc) && (w_acc_rd != REG_AW'(REG_ZERO));

  assign RegWrite = !w_empty && !wb_hold;
  assign w_pop    = RegWrite;

  regfile_wb_ctrl_wb_fifo #(
    .XLEN   (XLEN),
    .REG_AW (REG_AW),
    .DEPTH  (DEPTH)
  ) u_wb_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_rd   (w_acc_rd),
    .i_push_data (w_acc_data),
    .i_pop       (w_pop),
    .o_head_rd   (wrReg),
    .o_head_data (wrData),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (occupancy),
    .o_ent_valid (w_ent_valid),
    .o_ent_rd    (w_ent_rd)
  );

  // The retiring head still counts as busy: the register file captures it at the edge.
  always_comb begin
    rs1_busy = 1'b0;
    rs2_busy = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (w_ent_valid[i] && (w_ent_rd[i*REG_AW +: REG_AW] == q_rs1)) begin
        rs1_busy = 1'b1;
      end
      if (w_ent_valid[i] && (w_ent_rd[i*REG_AW +: REG_AW] == q_rs2)) begin
        rs2_busy = 1'b1;
      end
    end
    if (q_rs1 == REG_AW'(REG_ZERO)) begin
      rs1_busy = 1'b0;
    end
    if (q_rs2 == REG_AW'(REG_ZERO)) begin
      rs2_busy = 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Bench for regfile_wb_ctrl: hand-derived vector table, corner sequences, and random
// traffic checked against a queue-based model of the write-back order.
module tb_regfile_wb_ctrl;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              alu_valid;
  logic              alu_ready;
  logic [REG_AW-1:0] alu_rd;
  logic [XLEN-1:0]   alu_data;
  logic              ld_valid;
  logic              ld_ready;
  logic [REG_AW-1:0] ld_rd;
  logic [XLEN-1:0]   ld_data;
  logic              wb_hold;
  logic              RegWrite;
  logic [REG_AW-1:0] wrReg;
  logic [XLEN-1:0]   wrData;
  logic [REG_AW-1:0] q_rs1;
  logic [REG_AW-1:0] q_rs2;
  logic              rs1_busy;
  logic              rs2_busy;
  logic [2:0]        occupancy;

  regfile_wb_ctrl #(
    .XLEN   (XLEN),
    .REG_AW (REG_AW),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_rd     (ld_rd),
    .ld_data   (ld_data),
    .wb_hold   (wb_hold),
    .RegWrite  (RegWrite),
    .wrReg     (wrReg),
    .wrData    (wrData),
    .q_rs1     (q_rs1),
    .q_rs2     (q_rs2),
    .rs1_busy  (rs1_busy),
    .rs2_busy  (rs2_busy),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } ent_t;

  ent_t mq[$];

  typedef struct {
    logic              av;
    logic [REG_AW-1:0] ard;
    logic [XLEN-1:0]   adat;
    logic              lv;
    logic [REG_AW-1:0] lrd;
    logic [XLEN-1:0]   ldat;
    logic              hold;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              e_rw;
    logic [REG_AW-1:0] e_wrreg;
    logic [XLEN-1:0]   e_wrdata;
    logic              e_aready;
    logic              e_lready;
    logic [2:0]        e_occ;
    logic              e_b1;
    logic              e_b2;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic m_busy(input logic [REG_AW-1:0] rs);
    if (rs == 0) return 1'b0;
    foreach (mq[i]) if (mq[i].rd == rs) return 1'b1;
    return 1'b0;
  endfunction

  // Compare every output against the queue model for the current inputs.
  task automatic model_check(input string tag);
    logic e_full, e_rw;
    e_full = (mq.size() == DEPTH);
    e_rw   = (mq.size() != 0) && !wb_hold;
    chk({tag, "_rw"}, 64'(RegWrite), 64'(e_rw));
    if (e_rw) begin
      chk({tag, "_wrreg"}, 64'(wrReg), 64'(mq[0].rd));
      chk({tag, "_wrdata"}, 64'(wrData), 64'(mq[0].data));
    end
    chk({tag, "_aready"}, 64'(alu_ready), 64'(!e_full));
    chk({tag, "_lready"}, 64'(ld_ready), 64'(!e_full && !alu_valid));
    chk({tag, "_occ"}, 64'(occupancy), 64'(mq.size()));
    chk({tag, "_b1"}, 64'(rs1_busy), 64'(m_busy(q_rs1)));
    chk({tag, "_b2"}, 64'(rs2_busy), 64'(m_busy(q_rs2)));
  endtask

  // Clock edge; the model retires the head and appends the accepted request.
  task automatic advance();
    logic e_full, do_pop, acc;
    ent_t e;
    e_full = (mq.size() == DEPTH);
    do_pop = (mq.size() != 0) && !wb_hold;
    acc    = 1'b0;
    if (alu_valid && !e_full) begin
      acc = 1'b1; e.rd = alu_rd; e.data = alu_data;
    end else if (ld_valid && !e_full && !alu_valid) begin
      acc = 1'b1; e.rd = ld_rd; e.data = ld_data;
    end
    @(posedge clk);
    if (do_pop) void'(mq.pop_front());
    if (acc && e.rd != 0) mq.push_back(e);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid  = 1'b0; ld_rd  = '0; ld_data  = '0;
  endtask

  task automatic addv(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                      input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic rw, input logic [4:0] wreg, input logic [31:0] wdat,
                      input logic ar, input logic lr, input logic [2:0] occ,
                      input logic b1, input logic b2);
    vec_t v;
    v.av = av; v.ard = ard; v.adat = adat; v.lv = lv; v.lrd = lrd; v.ldat = ldat;
    v.hold = 1'b0; v.rs1 = rs1; v.rs2 = rs2; v.e_rw = rw; v.e_wrreg = wreg;
    v.e_wrdata = wdat; v.e_aready = ar; v.e_lready = lr; v.e_occ = occ;
    v.e_b1 = b1; v.e_b2 = b2;
    vecs.push_back(v);
  endtask

  initial begin
    logic saw_acc;
    reset   = 1'b0;
    wb_hold = 1'b0;
    q_rs1   = '0;
    q_rs2   = '0;
    idle_inputs();

    // Outputs in reset.
    #2;
    chk("rst_rw", 64'(RegWrite), 64'd0);
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_wrreg", 64'(wrReg), 64'd0);
    chk("rst_wrdata", 64'(wrData), 64'd0);
    chk("rst_aready", 64'(alu_ready), 64'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Outputs expected during each cycle, before the edge that samples the inputs.
    //   av ard adat          lv lrd ldat        rs1 rs2  rw wreg wdat         ar lr occ b1 b2
    addv(1, 5, 32'hDEADBEEF, 0, 0, 0,           5, 0,    0, 0, 0,             1, 0, 0, 0, 0);
    addv(0, 0, 0,            0, 0, 0,           5, 0,    1, 5, 32'hDEADBEEF,  1, 1, 1, 1, 0);
    addv(0, 0, 0,            0, 0, 0,           5, 0,    0, 0, 0,             1, 1, 0, 0, 0);
    addv(1, 3, 32'hA,        1, 7, 32'h11,      3, 7,    0, 0, 0,             1, 0, 0, 0, 0);
    addv(0, 0, 0,            1, 7, 32'h11,      3, 7,    1, 3, 32'hA,         1, 1, 1, 1, 0);
    addv(0, 0, 0,            0, 0, 0,           3, 7,    1, 7, 32'h11,        1, 1, 1, 0, 1);
    addv(0, 0, 0,            0, 0, 0,           3, 7,    0, 0, 0,             1, 1, 0, 0, 0);
    addv(1, 3, 32'hA,        0, 0, 0,           3, 3,    0, 0, 0,             1, 0, 0, 0, 0);
    addv(0, 0, 0,            1, 3, 32'hB,       3, 0,    1, 3, 32'hA,         1, 1, 1, 1, 0);
    addv(0, 0, 0,            0, 0, 0,           3, 0,    1, 3, 32'hB,         1, 1, 1, 1, 0);
    addv(0, 0, 0,            0, 0, 0,           3, 0,    0, 0, 0,             1, 1, 0, 0, 0);
    addv(1, 0, 32'hFFFF,     0, 0, 0,           0, 0,    0, 0, 0,             1, 0, 0, 0, 0);
    addv(0, 0, 0,            0, 0, 0,           0, 0,    0, 0, 0,             1, 1, 0, 0, 0);
    addv(0, 0, 0,            1, 0, 32'h1234,    0, 0,    0, 0, 0,             1, 1, 0, 0, 0);
    addv(0, 0, 0,            0, 0, 0,           0, 0,    0, 0, 0,             1, 1, 0, 0, 0);

    foreach (vecs[i]) begin
      alu_valid = vecs[i].av; alu_rd = vecs[i].ard; alu_data = vecs[i].adat;
      ld_valid  = vecs[i].lv; ld_rd  = vecs[i].lrd; ld_data  = vecs[i].ldat;
      wb_hold   = vecs[i].hold; q_rs1 = vecs[i].rs1; q_rs2 = vecs[i].rs2;
      #1;
      chk($sformatf("vec%0d_rw", i), 64'(RegWrite), 64'(vecs[i].e_rw));
      if (vecs[i].e_rw) begin
        chk($sformatf("vec%0d_wrreg", i), 64'(wrReg), 64'(vecs[i].e_wrreg));
        chk($sformatf("vec%0d_wrdata", i), 64'(wrData), 64'(vecs[i].e_wrdata));
      end
      chk($sformatf("vec%0d_aready", i), 64'(alu_ready), 64'(vecs[i].e_aready));
      chk($sformatf("vec%0d_lready", i), 64'(ld_ready), 64'(vecs[i].e_lready));
      chk($sformatf("vec%0d_occ", i), 64'(occupancy), 64'(vecs[i].e_occ));
      chk($sformatf("vec%0d_b1", i), 64'(rs1_busy), 64'(vecs[i].e_b1));
      chk($sformatf("vec%0d_b2", i), 64'(rs2_busy), 64'(vecs[i].e_b2));
      advance();
    end
    idle_inputs();

    // Hold: four writes fill the queue, the fifth is refused until draining frees a slot.
    wb_hold = 1'b1; q_rs1 = 5'd1; q_rs2 = 5'd5;
    for (int k = 0; k < 4; k++) begin
      alu_valid = 1'b1; alu_rd = 5'(k + 1); alu_data = 32'h100 + 32'(k);
      #1; model_check($sformatf("hold%0d", k)); advance();
    end
    alu_rd = 5'd5; alu_data = 32'h105;
    #1;
    chk("hold_full_occ", 64'(occupancy), 64'd4);
    chk("hold_full_aready", 64'(alu_ready), 64'd0);
    chk("hold_full_rw", 64'(RegWrite), 64'd0);
    model_check("hold4");
    advance();
    wb_hold = 1'b0;
    for (int j = 0; j < 5; j++) begin
      #1;
      chk($sformatf("drain%0d_rw", j), 64'(RegWrite), 64'd1);
      chk($sformatf("drain%0d_wrreg", j), 64'(wrReg), 64'(j + 1));
      if (j == 0) chk("drain0_no_passthru", 64'(alu_ready), 64'd0);
      model_check($sformatf("drain%0d", j));
      saw_acc = alu_valid && alu_ready;
      advance();
      if (saw_acc) alu_valid = 1'b0;
    end
    #1; model_check("drain_end"); advance();

    // Asynchronous reset with three writes queued.
    wb_hold = 1'b1; q_rs1 = 5'd9; q_rs2 = 5'd11;
    for (int k = 0; k < 3; k++) begin
      alu_valid = 1'b1; alu_rd = 5'(9 + k); alu_data = 32'hC0DE0000 + 32'(k);
      #1; model_check($sformatf("pre_rst%0d", k)); advance();
    end
    idle_inputs();
    #2;
    reset = 1'b0;
    #1;
    chk("arst_rw", 64'(RegWrite), 64'd0);
    chk("arst_occ", 64'(occupancy), 64'd0);
    chk("arst_b1", 64'(rs1_busy), 64'd0);
    chk("arst_b2", 64'(rs2_busy), 64'd0);
    chk("arst_wrreg", 64'(wrReg), 64'd0);
    mq.delete();
    @(posedge clk); #1;
    reset   = 1'b1;
    wb_hold = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1; model_check($sformatf("post_rst%0d", k)); advance();
    end

    // Random traffic against the model; small rd range forces collisions.
    for (int k = 0; k < 400; k++) begin
      alu_valid = ($urandom_range(0, 2) == 0);
      alu_rd    = 5'($urandom_range(0, 7));
      alu_data  = $urandom;
      ld_valid  = ($urandom_range(0, 1) == 0);
      ld_rd     = 5'($urandom_range(0, 7));
      ld_data   = $urandom;
      wb_hold   = ($urandom_range(0, 4) == 0);
      q_rs1     = 5'($urandom_range(0, 7));
      q_rs2     = 5'($urandom_range(0, 7));
      #1; model_check($sformatf("rnd%0d", k)); advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_wb_ctrl.md
Name: regfile_wb_ctrl

Overview:
Write-side front end for the 32x32 register file. It accepts register write requests from two producers: the ALU/execute path and the multi-cycle load unit. Requests are queued in order in a small FIFO and drained one per cycle onto the register file's single write port (RegWrite/wrReg/wrData). A scoreboard query tells issue logic whether a source register still has a write in flight.

Parameters:
XLEN, 32, data width
REG_AW, 5, register index width
DEPTH, 4, FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
alu_valid  in  1  ALU write request
alu_ready  out  1  ALU request accepted when valid&ready at clk edge
alu_rd  in  REG_AW  ALU destination register
alu_data  in  XLEN  ALU write data
ld_valid  in  1  load-unit write request
ld_ready  out  1  load request accepted when valid&ready at clk edge
ld_rd  in  REG_AW  load destination register
ld_data  in  XLEN  load write data
wb_hold  in  1  freeze draining (debug halt)
RegWrite  out  1  register file write enable
wrReg  out  REG_AW  register file write index
wrData  out  XLEN  register file write data
q_rs1, q_rs2  in  REG_AW  scoreboard query indices
rs1_busy, rs2_busy  out  1  queried register has a pending write
occupancy  out  $clog2(DEPTH)+1  valid FIFO entries

Behaviour:
- Reset (reset=0, asynchronous): FIFO emptied, pointers 0, occupancy=0, RegWrite=0, wrReg=0, wrData=0, busy outputs 0. Everything in flight is discarded. Deassertion is taken at the next clk edge.
- Readiness and arbitration:
  - alu_ready = !full.
  - ld_ready = !full && !alu_valid. ALU has fixed priority.
  - At most one request is accepted per cycle.
  - ready depends only on current state and alu_valid, never on rd or data.
- rd==0 requests complete the handshake normally but are not enqueued. occupancy and busy are unaffected.
- Enqueue: an accepted request with rd!=0 is written at the FIFO tail at the clk edge.
- Drain:
  - RegWrite = !empty && !wb_hold. wrReg/wrData are the head entry, driven combinationally from FIFO storage.
  - When RegWrite=1 the head pops at the same edge the register file captures it.
  - Latency: request accepted at edge N → RegWrite high during cycle N+1 → register file updated at edge N+1 (no hold, empty queue).
  - Throughput: 1 write per cycle.
- Full: ready is low even if a pop occurs that cycle. There is no full pass-through.
- Push and pop in the same cycle (not full): occupancy is unchanged and pointers advance modulo DEPTH.
- Ordering: strict acceptance order. Multiple writes to the same rd retire oldest first, so the last accepted value wins.
- wb_hold=1: RegWrite=0, no pop. Enqueue continues until full. On release, draining resumes from the unchanged head.
- Scoreboard:
  - rsN_busy = (q_rsN!=0) && (any valid entry, including the head, has rd==q_rsN). Combinational.
  - An entry retiring this cycle still reports busy, because the register file has not yet captured it.
  - A request being accepted this cycle is not yet visible.
- Combinational outputs (wrReg/wrData) hold the head value when idle. When empty they show stale storage, and RegWrite=0 gates them.

Decomposition:
- Shared constants file: XLEN, REG_AW, DEPTH defaults, REG_ZERO=0. These are shared with the register file and decode.
- Sub-module wb_fifo: storage, pointers, occupancy, full/empty, per-entry valid and rd exported for the scoreboard compare.
- Top level: arbitration, rd==0 filter, hold gating, busy CAM.

Test Plan:
- Reset with reset=0 mid-burst (3 entries queued) → RegWrite=0, occupancy=0, busy=0 immediately. After release, no stale write reaches the register file.
- ALU writes x5=0xDEADBEEF at edge N → RegWrite=1, wrReg=5, wrData=0xDEADBEEF in cycle N+1. rs1_busy(q_rs1=5)=1 in cycle N+1 and 0 in N+2.
- alu_valid and ld_valid both high → ALU accepted and ld_ready=0. Load (x7=0x11) accepted the next cycle. Retire order is ALU, then load.
- wb_hold=1 with 5 ALU requests to x1..x5 → 4 accepted, alu_ready=0 on the 5th, occupancy=4. Release hold → x1..x4 written on 4 consecutive cycles, then x5 is accepted.
- ALU x3=0xA, then load x3=0xB back-to-back → register file writes 0xA then 0xB. busy(x3) stays 1 until the 0xB retirement cycle ends.
- Request with rd=0, data 0xFFFF → handshake completes, occupancy stays 0, RegWrite never asserts, rs1_busy(q_rs1=0)=0.
